pipe_stage_skid: RTL
====================

Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline registers, such as the EX/MEM boundary.
- Carries a DATA_W payload bus plus a CTRL_W control bus across one stage boundary using a valid/ready handshake.
- A 2-entry skid buffer gives full throughput under back-pressure with registered in_ready; a synchronous Flush squashes in-flight entries.
- Control bits read zero whenever the stage holds a bubble, so downstream RegWrite/MemWrite-type strobes can never fire spuriously.
- A saturating stall counter supports performance debug.

Parameters:
- DATA_W, 64, payload width (PC, ALU result, store data, etc.)
- CTRL_W, 8, control-bit width (RegWrite, MemRead, Branch, ...); forced to zero on bubble/flush
- CNT_W, 16, stall counter width

Ports:
- Clk  input  1  rising-edge clock
- Clr_n  input  1  asynchronous active-low reset
- Flush  input  1  synchronous squash of all held entries
- in_valid  input  1  upstream entry valid
- in_ready  output  1  stage can accept (registered)
- in_data  input  DATA_W  upstream payload
- in_ctrl  input  CTRL_W  upstream control bits
- out_valid  output  1  downstream entry valid
- out_ready  input  1  downstream accepts
- out_data  output  DATA_W  head payload
- out_ctrl  output  CTRL_W  head control bits; 0 when out_valid=0
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Storage: main (head) register and skid register, each holding data, ctrl and a valid bit.
- States: EMPTY (neither valid), ONE (main valid), TWO (both valid).
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Reset (Clr_n=0, asynchronous):
  - State goes to EMPTY.
  - All data/ctrl registers, in_ready, out_valid and stall_cnt go to 0.
  - in_ready rises at the first Clk edge after Clr_n deasserts.
- in_ready is a register loaded every edge with (next_state != TWO). It is never a combinational function of out_ready.
- out_valid = (state != EMPTY). out_data = main data. out_ctrl = main ctrl when out_valid, else 0.
- Transitions (Flush=0):
  - EMPTY: in_fire -> ONE, main <= in.
  - ONE: in_fire & out_fire -> ONE, main <= in. in_fire & !out_fire -> TWO, skid <= in. !in_fire & out_fire -> EMPTY. Otherwise hold.
  - TWO: out_fire -> ONE, main <= skid, skid ctrl cleared. Otherwise hold; in_ready is already 0.
- Ordering: strict FIFO. Latency is 1 cycle from in_fire to out_valid when the stage is empty. No entry is lost or duplicated.
- Flush=1 at an edge:
  - State goes to EMPTY; main/skid ctrl and valid bits are cleared; data may hold.
  - Any in_fire in that cycle is discarded.
  - An out_fire in that same cycle still counts as consumed downstream.
  - in_ready=1 at the next cycle.
- Flush and reset: reset dominates Flush. Flush dominates all handshake transitions.
- stall_cnt:
  - Increments by 1 each edge where out_valid & !out_ready.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset; Flush does not clear it.
- Reset mid-transfer discards all entries immediately. No X may appear on any output after reset.

Test Plan:
- Streaming: reset, hold out_ready=1, drive in_valid=1 with in_data=1..10 and in_ctrl=8'hA5 for 10 cycles -> out_data 1..10 in order, one per cycle after 1-cycle latency; in_ready stays 1; stall_cnt=0.
- Back-pressure: out_ready=0 while sending 1,2,3 -> state reaches TWO after entries 1,2; in_ready=0 the cycle after entry 2 is accepted; entry 3 is held upstream. Raise out_ready -> outputs 1,2,3 in order with none lost; stall_cnt equals the number of out_ready=0 cycles with out_valid=1.
- Flush while full: state TWO with entries 0x11,0x22, then Flush=1 with in_valid=1, in_data=0x33 -> next cycle out_valid=0, out_ctrl=0, in_ready=1; 0x33 never appears at the output.
- Bubble control masking: in_valid=0 for 3 cycles after in_ctrl=8'hFF was consumed -> out_ctrl=0 in all 3 cycles.
- Async reset mid-operation: assert Clr_n=0 between clock edges while in state TWO -> out_valid, in_ready, out_ctrl and stall_cnt go to 0 immediately; in_ready=1 one edge after release.
- Saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and holds at 15.

Source files
------------

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_skid
//  Description : Valid/ready pipeline stage with a 2-entry skid buffer,
//                synchronous flush, bubble-masked control bits and a
//                saturating stall counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_skid #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Clr_n,
    input  logic              Flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Encoding doubles as the valid bits: bit0 = main valid, bit1 = skid valid.
    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] ONE   = 2'b01;
    localparam logic [1:0] TWO   = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]        state;
    logic [1:0]        next_state;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              in_fire;
    logic              out_fire;
    logic              load_main_in;
    logic              load_skid_in;
    logic              load_main_skid;

    assign out_valid = (state != EMPTY);
    assign out_data  = main_data;
    assign out_ctrl  = out_valid ? main_ctrl : '0;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        next_state     = state;
        load_main_in   = 1'b0;
        load_skid_in   = 1'b0;
        load_main_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    next_state   = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (in_fire) begin
                    next_state   = TWO;
                    load_skid_in = 1'b1;
                end else if (out_fire) begin
                    next_state   = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    next_state     = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: next_state = EMPTY;
        endcase
        // Flush overrides every handshake decision, including a same-cycle in_fire.
        if (Flush) begin
            next_state     = EMPTY;
            load_main_in   = 1'b0;
            load_skid_in   = 1'b0;
            load_main_skid = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            state     <= EMPTY;
            in_ready  <= 1'b0;
            main_data <= '0;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else begin
            state    <= next_state;
            in_ready <= (next_state != TWO);
            if (Flush) begin
                main_ctrl <= '0;
                skid_ctrl <= '0;
            end else begin
                if (load_main_in) begin
                    main_data <= in_data;
                    main_ctrl <= in_ctrl;
                end
                if (load_skid_in) begin
                    skid_data <= in_data;
                    skid_ctrl <= in_ctrl;
                end
                if (load_main_skid) begin
                    main_data <= skid_data;
                    main_ctrl <= skid_ctrl;
                    skid_ctrl <= '0;
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire
